// File: rtl/autoconfig_sequencer.sv
// Amiga Autoconfig chain controller: walks boards, serves nibble ROM reads, captures bases.
// Define AUTOCONFIG_ETH_EN to include the ETH board (index 4) in the chain.
module autoconfig_sequencer #(
  parameter int unsigned       ROM_AW     = 9,
  parameter logic [ROM_AW-1:0] Z2_SIZE_A  = ROM_AW'('h001),
  parameter logic [ROM_AW-1:0] Z3C_SIZE_A = ROM_AW'('h0C1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sel,
  input  logic [6:0]        addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [15:0]       wdata,
  output logic [3:0]        rdata,
  output logic              ack,
  input  logic [4:0]        board_en,
  input  logic [3:0]        cfg_z2_size,
  input  logic [3:0]        cfg_z3c_size,
  output logic [ROM_AW-1:0] rom_a_read,
  input  logic [3:0]        rom_q,
  output logic [ROM_AW-1:0] rom_a_write,
  output logic [3:0]        rom_d,
  output logic              rom_we,
  output logic [7:0]        z2_base,
  output logic              z2_cfg,
  output logic [15:0]       z3_base0,
  output logic [15:0]       z3_base1,
  output logic [15:0]       z3_base2,
  output logic [2:0]        z3_cfg,
  output logic [15:0]       eth_base,
  output logic              eth_cfg,
  output logic              cfg_done
);

  typedef enum logic [2:0] {
    S_INIT0, S_INIT1, S_SKIP, S_IDLE, S_RD1, S_RD2, S_RD3, S_WR
  } state_e;

  // addr carries byte offset bits [7:1], so register byte offsets are halved here
  localparam logic [6:0] OFS_Z3_BASE = 7'h22;  // byte 'h44
  localparam logic [6:0] OFS_Z2_BASE = 7'h24;  // byte 'h48
  localparam logic [6:0] OFS_SHUTUP  = 7'h26;  // byte 'h4C

`ifdef AUTOCONFIG_ETH_EN
  localparam logic [2:0] LAST    = 3'd4;
  localparam logic [4:0] EN_MASK = 5'b11111;
  logic [15:0] eth_base_q, eth_base_d;
  logic        eth_cfg_q, eth_cfg_d;
`else
  localparam logic [2:0] LAST    = 3'd3;
  localparam logic [4:0] EN_MASK = 5'b01111;
`endif

  state_e            state_q, state_d;
  logic [2:0]        board_idx_q, board_idx_d;
  logic [ROM_AW-1:0] rom_a_read_q, rom_a_read_d;
  logic [6:0]        wr_ofs_q, wr_ofs_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic [3:0]        rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              cfg_done_q, cfg_done_d;
  logic [7:0]        z2_base_q, z2_base_d;
  logic              z2_cfg_q, z2_cfg_d;
  logic [2:0][15:0]  z3_base_q, z3_base_d;
  logic [2:0]        z3_cfg_q, z3_cfg_d;
  logic [7:0]        en_vec;
  logic              advance;

  // Widened so indexing with board_idx past LAST stays in range.
  assign en_vec = {3'b000, board_en & EN_MASK};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d      = state_q;
    board_idx_d  = board_idx_q;
    rom_a_read_d = rom_a_read_q;
    wr_ofs_d     = wr_ofs_q;
    wr_data_d    = wr_data_q;
    rdata_d      = rdata_q;
    ack_d        = 1'b0;
    cfg_done_d   = cfg_done_q;
    z2_base_d    = z2_base_q;
    z2_cfg_d     = z2_cfg_q;
    z3_base_d    = z3_base_q;
    z3_cfg_d     = z3_cfg_q;
`ifdef AUTOCONFIG_ETH_EN
    eth_base_d   = eth_base_q;
    eth_cfg_d    = eth_cfg_q;
`endif
    advance      = 1'b0;

    case (state_q)
      S_INIT0: state_d = S_INIT1;
      S_INIT1: state_d = S_SKIP;
      S_SKIP: begin
        if (board_idx_q > LAST) begin
          cfg_done_d = 1'b1;
          state_d    = S_IDLE;
        end else if (!en_vec[board_idx_q]) begin
          board_idx_d = board_idx_q + 3'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (sel && wr) begin
          wr_ofs_d  = addr;
          wr_data_d = wdata;
          state_d   = S_WR;
        end else if (sel && rd) begin
          rom_a_read_d = ROM_AW'({board_idx_q, addr[6:1]});
          state_d      = S_RD1;
        end
      end
      S_RD1: state_d = S_RD2;
      S_RD2: state_d = S_RD3;
      S_RD3: begin
        ack_d   = 1'b1;
        rdata_d = cfg_done_q ? 4'hF : rom_q;
        state_d = S_IDLE;
      end
      S_WR: begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
        if (!cfg_done_q) begin
          if (wr_ofs_q == OFS_SHUTUP) begin
            advance = 1'b1;
          end else if (board_idx_q == 3'd0 && wr_ofs_q == OFS_Z2_BASE) begin
            z2_base_d = wr_data_q[15:8];
            z2_cfg_d  = 1'b1;
            advance   = 1'b1;
          end else if (board_idx_q != 3'd0 && wr_ofs_q == OFS_Z3_BASE) begin
            case (board_idx_q)
              3'd1: begin z3_base_d[0] = wr_data_q; z3_cfg_d[0] = 1'b1; advance = 1'b1; end
              3'd2: begin z3_base_d[1] = wr_data_q; z3_cfg_d[1] = 1'b1; advance = 1'b1; end
              3'd3: begin z3_base_d[2] = wr_data_q; z3_cfg_d[2] = 1'b1; advance = 1'b1; end
`ifdef AUTOCONFIG_ETH_EN
              3'd4: begin eth_base_d = wr_data_q; eth_cfg_d = 1'b1; advance = 1'b1; end
`endif
              default: ;
            endcase
          end
        end
        if (advance) begin
          board_idx_d = board_idx_q + 3'd1;
          state_d     = S_SKIP;
        end
      end
      default: state_d = S_INIT0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous (sampled on the clock edge) and all state uses non-blocking updates.
    if (!reset_n) begin
      state_q      <= S_INIT0;
      board_idx_q  <= 3'd0;
      rom_a_read_q <= '0;
      wr_ofs_q     <= '0;
      wr_data_q    <= '0;
      rdata_q      <= 4'hF;
      ack_q        <= 1'b0;
      cfg_done_q   <= 1'b0;
      z2_base_q    <= '0;
      z2_cfg_q     <= 1'b0;
      z3_base_q    <= '0;
      z3_cfg_q     <= '0;
`ifdef AUTOCONFIG_ETH_EN
      eth_base_q   <= '0;
      eth_cfg_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      board_idx_q  <= board_idx_d;
      rom_a_read_q <= rom_a_read_d;
      wr_ofs_q     <= wr_ofs_d;
      wr_data_q    <= wr_data_d;
      rdata_q      <= rdata_d;
      ack_q        <= ack_d;
      cfg_done_q   <= cfg_done_d;
      z2_base_q    <= z2_base_d;
      z2_cfg_q     <= z2_cfg_d;
      z3_base_q    <= z3_base_d;
      z3_cfg_q     <= z3_cfg_d;
`ifdef AUTOCONFIG_ETH_EN
      eth_base_q   <= eth_base_d;
      eth_cfg_q    <= eth_cfg_d;
`endif
    end
  end

  // Size patch writes are decoded from state; held off while reset is asserted.
  assign rom_we      = reset_n && (state_q == S_INIT0 || state_q == S_INIT1);
  assign rom_a_write = (state_q == S_INIT1) ? Z3C_SIZE_A : Z2_SIZE_A;
  assign rom_d       = (state_q == S_INIT1) ? cfg_z3c_size : cfg_z2_size;

  assign rom_a_read = rom_a_read_q;
  assign rdata      = rdata_q;
  assign ack        = ack_q;
  assign cfg_done   = cfg_done_q;
  assign z2_base    = z2_base_q;
  assign z2_cfg     = z2_cfg_q;
  assign z3_base0   = z3_base_q[0];
  assign z3_base1   = z3_base_q[1];
  assign z3_base2   = z3_base_q[2];
  assign z3_cfg     = z3_cfg_q;
`ifdef AUTOCONFIG_ETH_EN
  assign eth_base   = eth_base_q;
  assign eth_cfg    = eth_cfg_q;
`else
  assign eth_base   = 16'h0000;
  assign eth_cfg    = 1'b0;
`endif

endmodule
